// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flush and memory-busy freeze.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned ADDR_W            = 5,
    parameter int unsigned LOAD_STALL_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W             = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dc_rs1,
    input  logic [ADDR_W-1:0] dc_rs2,
    input  logic              dc_use_rs1,
    input  logic              dc_use_rs2,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic              alu_isLW,
    input  logic              alu_br_taken,
    input  logic              mem_busy,
    output logic              pc_hold,
    output logic              if_dc_hold,
    output logic              if_dc_flush,
    output logic              dc_alu_hold,
    output logic              dc_alu_bubble,
    output logic              alu_mem_hold,
    output logic [1:0]        state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_ldstall,
    output logic [CNT_W-1:0]  cnt_flush,
    output logic [CNT_W-1:0]  cnt_memwait
`endif
);

    localparam int unsigned CntW = 2;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLdStall = 2'd1,
        StMemWait = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              load_use;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = alu_isLW && (alu_rd != '0) &&
                      ((dc_use_rs1 && (dc_rs1 == alu_rd)) ||
                       (dc_use_rs2 && (dc_rs2 == alu_rd)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_hold       = 1'b0;
        if_dc_hold    = 1'b0;
        if_dc_flush   = 1'b0;
        dc_alu_hold   = 1'b0;
        dc_alu_bubble = 1'b0;
        alu_mem_hold  = 1'b0;

        case (state_q)
            // MEMWAIT with memory ready falls straight into the RUN rules.
            StRun, StMemWait: begin
                if (mem_busy) begin
                    pc_hold      = 1'b1;
                    if_dc_hold   = 1'b1;
                    dc_alu_hold  = 1'b1;
                    alu_mem_hold = 1'b1;
                    state_d      = StMemWait;
                end else if (alu_br_taken) begin
                    if_dc_flush   = 1'b1;
                    dc_alu_bubble = 1'b1;
                    state_d       = StRun;
                end else if (load_use) begin
                    pc_hold       = 1'b1;
                    if_dc_hold    = 1'b1;
                    dc_alu_bubble = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        cnt_d   = CntW'(LOAD_STALL_CYCLES - 1);
                        state_d = StLdStall;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    state_d = StRun;
                end
            end
            StLdStall: begin
                if (mem_busy) begin
                    pc_hold      = 1'b1;
                    if_dc_hold   = 1'b1;
                    dc_alu_hold  = 1'b1;
                    alu_mem_hold = 1'b1;
                end else begin
                    pc_hold       = 1'b1;
                    if_dc_hold    = 1'b1;
                    dc_alu_bubble = 1'b1;
                    cnt_d         = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase

        // Controls are silenced in any cycle where reset is being sampled.
        if (rst) begin
            pc_hold       = 1'b0;
            if_dc_hold    = 1'b0;
            if_dc_flush   = 1'b0;
            dc_alu_hold   = 1'b0;
            dc_alu_bubble = 1'b0;
            alu_mem_hold  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state = rst ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_ldstall_q, cnt_ldstall_d;
    logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
    logic [CNT_W-1:0] cnt_memwait_q, cnt_memwait_d;

    // A bubble without a flush can only come from a load-use stall.
    always_comb begin
        cnt_ldstall_d = cnt_ldstall_q;
        cnt_flush_d   = cnt_flush_q;
        cnt_memwait_d = cnt_memwait_q;
        if (dc_alu_bubble && !if_dc_flush && (cnt_ldstall_q != '1)) begin
            cnt_ldstall_d = cnt_ldstall_q + CNT_W'(1);
        end
        if (if_dc_flush && (cnt_flush_q != '1)) begin
            cnt_flush_d = cnt_flush_q + CNT_W'(1);
        end
        if (alu_mem_hold && (cnt_memwait_q != '1)) begin
            cnt_memwait_d = cnt_memwait_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ldstall_q <= '0;
            cnt_flush_q   <= '0;
            cnt_memwait_q <= '0;
        end else begin
            cnt_ldstall_q <= cnt_ldstall_d;
            cnt_flush_q   <= cnt_flush_d;
            cnt_memwait_q <= cnt_memwait_d;
        end
    end

    assign cnt_ldstall = cnt_ldstall_q;
    assign cnt_flush   = cnt_flush_q;
    assign cnt_memwait = cnt_memwait_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (1, 2 and 3 load-stall cycles) share one stimulus
// stream and are checked every cycle against a bubbles-owed reference model.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] dc_rs1, dc_rs2, alu_rd;
    logic       dc_use_rs1, dc_use_rs2, alu_isLW, alu_br_taken, mem_busy;

    // {state[1:0], pc_hold, if_dc_hold, if_dc_flush, dc_alu_hold, dc_alu_bubble, alu_mem_hold}
    logic [7:0] obs [3];

    int vectors;
    int miscompares;

    // Reference model: bubbles still owed and whether the previous cycle was a freeze.
    int   owed [3];
    bit   froze [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       ph, ih, ifl, dh, db, ah;
        logic [1:0] st;
        hazard_ctrl #(
            .ADDR_W            (5),
            .LOAD_STALL_CYCLES (g + 1)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .dc_rs1        (dc_rs1),
            .dc_rs2        (dc_rs2),
            .dc_use_rs1    (dc_use_rs1),
            .dc_use_rs2    (dc_use_rs2),
            .alu_rd        (alu_rd),
            .alu_isLW      (alu_isLW),
            .alu_br_taken  (alu_br_taken),
            .mem_busy      (mem_busy),
            .pc_hold       (ph),
            .if_dc_hold    (ih),
            .if_dc_flush   (ifl),
            .dc_alu_hold   (dh),
            .dc_alu_bubble (db),
            .alu_mem_hold  (ah),
            .state         (st)
        );
        assign obs[g] = {st, ph, ih, ifl, dh, db, ah};
    end

    function automatic logic [7:0] expect_and_advance(input int i);
        int         stall_len;
        bit         lu;
        logic [1:0] st;
        logic [5:0] ctl;
        stall_len = i + 1;
        lu = alu_isLW && (alu_rd != 5'd0) &&
             ((dc_use_rs1 && dc_rs1 == alu_rd) || (dc_use_rs2 && dc_rs2 == alu_rd));
        if (rst) begin
            owed[i]  = 0;
            froze[i] = 1'b0;
            return 8'h00;
        end
        st = (owed[i] > 0) ? 2'd1 : (froze[i] ? 2'd2 : 2'd0);
        if (mem_busy) begin
            ctl = 6'b110101;
            // A freeze during a stall leaves the owed bubbles untouched.
            froze[i] = (owed[i] == 0);
        end else begin
            froze[i] = 1'b0;
            if (owed[i] > 0) begin
                ctl = 6'b110010;
                owed[i]--;
            end else if (alu_br_taken) begin
                ctl = 6'b001010;
            end else if (lu) begin
                ctl = 6'b110010;
                owed[i] = stall_len - 1;
            end else begin
                ctl = 6'b000000;
            end
        end
        return {st, ctl};
    endfunction

    task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input logic [4:0] rd, input bit lw,
                        input bit br, input bit busy, input string tag);
        logic [7:0] exp;
        rst          = r;
        dc_rs1       = rs1;
        dc_rs2       = rs2;
        dc_use_rs1   = u1;
        dc_use_rs2   = u2;
        alu_rd       = rd;
        alu_isLW     = lw;
        alu_br_taken = br;
        mem_busy     = busy;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            exp = expect_and_advance(i);
            vectors++;
            assert (obs[i] === exp) else begin
                miscompares++;
                $error("FAIL %s L=%0d observed=%b expected=%b", tag, i + 1, obs[i], exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 3; i++) begin
            owed[i]  = 0;
            froze[i] = 1'b0;
        end
        #1;

        // Reset overrides busy and branch; holds appear as soon as it drops.
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, "reset0");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, "reset1");
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, "memwait0");
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, "memwait_br");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, "release_flush");
        idle(1, "idle");

        step(0, 0, 5, 0, 1, 5, 1, 0, 0, "lu_rs2");
        idle(3, "lu_rs2_tail");
        step(0, 0, 0, 1, 1, 0, 1, 0, 0, "x0_no_stall");
        idle(2, "x0_tail");

        step(0, 7, 3, 1, 0, 7, 1, 0, 0, "lu_rs1");
        idle(3, "lu_rs1_tail");
        step(0, 7, 0, 0, 1, 7, 1, 0, 0, "rs1_match_unused");
        idle(1, "idle");

        step(0, 9, 9, 1, 1, 9, 1, 1, 0, "br_over_lu");
        idle(2, "br_tail");

        step(0, 4, 0, 1, 0, 4, 1, 0, 0, "lu_then_busy");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, "busy_in_stall");
        idle(3, "stall_resume");

        step(0, 6, 0, 1, 0, 6, 1, 0, 0, "lu_then_br");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, "br_after_lu");
        idle(3, "idle");

        step(0, 8, 0, 1, 0, 8, 1, 0, 0, "lu_then_rst");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_stall");
        idle(3, "post_rst");

        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(63) == 0),
                 5'($urandom_range(3)), 5'($urandom_range(3)),
                 $urandom_range(1) == 1, $urandom_range(1) == 1,
                 5'($urandom_range(3)), $urandom_range(1) == 1,
                 $urandom_range(5) == 0, $urandom_range(3) == 0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
